// File: rtl/backend_prog_ctrl.sv
// Programming sequencer for the backend chip. It holds the chip in reset, shifts a
// 5-bit gain word out MSB first on sclk/sdin, then waits for ready or times out.
module backend_prog_ctrl #(
  parameter int CLK_DIV     = 4,
  parameter int RST_CYCLES  = 8,
  parameter int RDY_TIMEOUT = 64
) (
  input  logic       i_clk,
  input  logic       i_resetbAll,
  input  logic       i_start,
  input  logic [1:0] i_gainA1,
  input  logic [2:0] i_gainA2,
  input  logic       i_ready,
  output logic       o_chip_resetb,
  output logic       o_sclk,
  output logic       o_sdin,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_timeout,
  output logic [2:0] o_state
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(RDY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST      = 3'd1,
    S_SHIFT    = 3'd2,
    S_WAIT_RDY = 3'd3,
    S_DONE     = 3'd4,
    S_ERR      = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    shreg_q, shreg_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          sclk_q, sclk_d;
  logic          sdin_q, sdin_d;
  logic          chip_resetb_q, chip_resetb_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic          rdy_meta_q, rdy_s_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    rst_cnt_d = rst_cnt_q;
    timer_d   = timer_q;
    sclk_d    = sclk_q;
    sdin_d    = sdin_q;
    unique case (state_q)
      S_IDLE: begin
        sclk_d = 1'b0;
        sdin_d = 1'b0;
        if (i_start) begin
          shreg_d   = {i_gainA2, i_gainA1};
          rst_cnt_d = '0;
          state_d   = S_RST;
        end
      end
      S_RST: begin
        if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
          state_d   = S_SHIFT;
          phase_d   = '0;
          bit_cnt_d = '0;
          sclk_d    = 1'b0;
          sdin_d    = shreg_q[4];
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (phase_q == PW'(CLK_DIV - 1)) begin
          phase_d = '0;
          sclk_d  = ~sclk_q;
          // data only moves on the falling toggle, keeping it centred on each rise
          if (sclk_q) begin
            if (bit_cnt_q == 3'd4) begin
              state_d = S_WAIT_RDY;
              sdin_d  = 1'b0;
              timer_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              shreg_d   = {shreg_q[3:0], 1'b0};
              sdin_d    = shreg_q[3];
            end
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_WAIT_RDY: begin
        if (rdy_s_q) begin
          state_d = S_DONE;
        end else if (timer_q == TW'(RDY_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    chip_resetb_d = (state_d != S_RST);
    busy_d        = (state_d == S_RST) || (state_d == S_SHIFT) || (state_d == S_WAIT_RDY);
    done_d        = (state_d == S_DONE);
    timeout_d     = (state_d == S_ERR);
  end

  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      state_q       <= S_IDLE;
      shreg_q       <= '0;
      phase_q       <= '0;
      bit_cnt_q     <= '0;
      rst_cnt_q     <= '0;
      timer_q       <= '0;
      sclk_q        <= 1'b0;
      sdin_q        <= 1'b0;
      chip_resetb_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      rdy_meta_q    <= 1'b0;
      rdy_s_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      phase_q       <= phase_d;
      bit_cnt_q     <= bit_cnt_d;
      rst_cnt_q     <= rst_cnt_d;
      timer_q       <= timer_d;
      sclk_q        <= sclk_d;
      sdin_q        <= sdin_d;
      chip_resetb_q <= chip_resetb_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      rdy_meta_q    <= i_ready;
      rdy_s_q       <= rdy_meta_q;
    end
  end

  assign o_chip_resetb = chip_resetb_q;
  assign o_sclk        = sclk_q;
  assign o_sdin        = sdin_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_timeout     = timeout_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_backend_prog_ctrl.sv
// Randomized bench for backend_prog_ctrl: each run is observed at the pins and
// compared with frame, timing and outcome values derived from the sequencing rules.
module tb_backend_prog_ctrl;

  localparam int CLK_DIV     = 4;
  localparam int RST_CYCLES  = 8;
  localparam int RDY_TIMEOUT = 64;

  logic       i_clk = 1'b0;
  logic       i_resetbAll;
  logic       i_start;
  logic [1:0] i_gainA1;
  logic [2:0] i_gainA2;
  logic       i_ready;
  logic       o_chip_resetb, o_sclk, o_sdin, o_busy, o_done, o_timeout;
  logic [2:0] o_state;

  int total = 0;
  int bad   = 0;

  backend_prog_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .RST_CYCLES (RST_CYCLES),
    .RDY_TIMEOUT(RDY_TIMEOUT)
  ) dut (
    .i_clk        (i_clk),
    .i_resetbAll  (i_resetbAll),
    .i_start      (i_start),
    .i_gainA1     (i_gainA1),
    .i_gainA2     (i_gainA2),
    .i_ready      (i_ready),
    .o_chip_resetb(o_chip_resetb),
    .o_sclk       (o_sclk),
    .o_sdin       (o_sdin),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_timeout    (o_timeout),
    .o_state      (o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pins();
    return int'({o_chip_resetb, o_sclk, o_sdin, o_busy, o_done, o_timeout, o_state});
  endfunction

  // One programming run; rdy_k is the WAIT_RDY edge index after which i_ready rises (-1: never).
  task automatic do_run(input logic [1:0] a1, input logic [2:0] a2, input int rdy_k, input bit poke);
    int low = 0, shift_c = 0, rises = 0, hi = 0, bad_hi = 0, busy_bad = 0, sclk_bad = 0;
    int k = -1, end_k = -1, dones = 0, tos = 0, outc = 0, exp_out, exp_k;
    logic [4:0] bits = '0;
    logic prev_sclk = 1'b0;
    bit finished = 0;
    bit exp_busy;
    i_gainA1 = a1;
    i_gainA2 = a2;
    i_start  = 1'b1;
    for (int n = 0; n < 400 && !finished; n++) begin
      @(posedge i_clk); #1;
      i_start  = 1'b0;
      i_gainA1 = ~a1;
      i_gainA2 = ~a2;
      if (!o_chip_resetb) low++;
      exp_busy = (o_state == 3'd1) || (o_state == 3'd2) || (o_state == 3'd3);
      if (o_busy !== exp_busy) busy_bad++;
      if (o_state != 3'd2 && o_sclk) sclk_bad++;
      if (o_state == 3'd2) shift_c++;
      if (o_sclk && !prev_sclk) begin
        bits = {bits[3:0], o_sdin};
        rises++;
        hi = 0;
      end
      if (o_sclk) hi++;
      if (prev_sclk && !o_sclk && hi != CLK_DIV) bad_hi++;
      prev_sclk = o_sclk;
      if (poke && o_state == 3'd2 && shift_c == 7) i_start = 1'b1;
      if (k < 0 && o_state == 3'd3) k = 0;
      else if (k >= 0) k++;
      if (o_done) begin dones++; end_k = k; outc = 1; end
      if (o_timeout) begin tos++; end_k = k; outc = 2; end
      if (k >= 0 && k == rdy_k) i_ready = 1'b1;
      if (o_state == 3'd0 && outc != 0) finished = 1;
    end
    i_ready = 1'b0;
    if (rdy_k >= 0 && rdy_k + 3 <= RDY_TIMEOUT) begin
      exp_out = 1; exp_k = rdy_k + 3;
    end else begin
      exp_out = 2; exp_k = RDY_TIMEOUT;
    end
    check("finished", int'(finished), 1);
    check("rst_low", low, RST_CYCLES);
    check("frame", int'(bits), int'({a2, a1}));
    check("rises", rises, 5);
    check("sclk_high", bad_hi, 0);
    check("shift_len", shift_c, 10 * CLK_DIV);
    check("busy", busy_bad, 0);
    check("sclk_idle", sclk_bad, 0);
    check("outcome", outc, exp_out);
    check("outcome_cyc", end_k, exp_k);
    check("done_cnt", dones, (exp_out == 1) ? 1 : 0);
    check("to_cnt", tos, (exp_out == 2) ? 1 : 0);
    check("end_state", int'(o_state), 0);
  endtask

  // Starts a run, asserts reset mid-clock once the target state is reached, checks the abort.
  task automatic reset_mid(input int target);
    bit hit = 0;
    i_gainA1 = 2'($urandom);
    i_gainA2 = 3'($urandom);
    i_start  = 1'b1;
    for (int n = 0; n < 300 && !hit; n++) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      if (int'(o_state) == target && (target != 2 || o_sclk)) hit = 1;
    end
    check("reach_state", int'(hit), 1);
    #2 i_resetbAll = 1'b0;
    #1;
    check("abort_sclk", int'(o_sclk), 0);
    check("abort_pins", pins(), 0);
    #4 i_resetbAll = 1'b1;
    @(posedge i_clk); #1;
    check("rel_resetb", int'(o_chip_resetb), 1);
    check("rel_state", int'(o_state), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_resetbAll = 1'b0;
    i_start     = 1'b0;
    i_gainA1    = '0;
    i_gainA2    = '0;
    i_ready     = 1'b0;
    repeat (3) @(posedge i_clk);
    #3;
    check("rst_pins", pins(), 0);
    i_resetbAll = 1'b1;
    @(posedge i_clk); #1;
    check("first_resetb", int'(o_chip_resetb), 1);
    check("first_state", int'(o_state), 0);

    do_run(2'b10, 3'b101, 5, 1'b0);
    do_run(2'($urandom), 3'($urandom), -1, 1'b0);
    do_run(2'($urandom), 3'($urandom), RDY_TIMEOUT - 3, 1'b0);
    do_run(2'($urandom), 3'($urandom), RDY_TIMEOUT - 2, 1'b0);
    do_run(2'b01, 3'b010, 0, 1'b1);

    reset_mid(3);
    do_run(2'($urandom), 3'($urandom), 2, 1'b0);
    reset_mid(2);
    do_run(2'b11, 3'b100, 10, 1'b0);

    for (int r = 0; r < 12; r++) begin
      int rk;
      rk = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, RDY_TIMEOUT + 4));
      do_run(2'($urandom), 3'($urandom), rk, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
